uart_tx_dev: RTL

Memory-mapped UART transmitter on the core's data bus, sitting downstream of the core's operand port alongside the memory and 7-segment devices. It accepts bytes written by software into an 8-entry FIFO and serialises them on a single TX pin as 8N1 frames at a software-programmable bit rate. A status word lets software poll for space and detect dropped writes. It is the synthesisable counterpart of the simulation-only serial device.

---
 rtl/uart_tx_dev_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_tx_dev.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_dev_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and transmit FSM states.
package uart_tx_dev_pkg;

  localparam logic [31:0] UART_TXDATA = 32'd0;
  localparam logic [31:0] UART_STATUS = 32'd1;
  localparam logic [31:0] UART_DIV    = 32'd2;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with read-first semantics: a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers on the data
// bus, byte FIFO, programmable bit timer and transmit FSM.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h20,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        txd
);

  logic                hit_tx, hit_st, hit_div;
  logic                wr_tx, wr_div, rd_st, rd_en;
  logic [31:0]         rd_data;
  logic [15:0]         div;
  logic [15:0]         timer;
  logic [7:0]          shift;
  logic [7:0]          fifo_rdata;
  logic [2:0]          bit_cnt;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_full, fifo_empty;
  logic                pop, bit_end, overflow;
  logic                unused_data_hi;
  tx_state_e           state;

  assign hit_tx  = (addr == BASE + UART_TXDATA);
  assign hit_st  = (addr == BASE + UART_STATUS);
  assign hit_div = (addr == BASE + UART_DIV);
  assign wr_tx   = enable & rw & hit_tx;
  assign wr_div  = enable & rw & hit_div;
  assign rd_st   = enable & ~rw & hit_st;
  assign rd_en   = enable & ~rw & (hit_tx | hit_st | hit_div);
  assign unused_data_hi = ^data[31:16];

  assign bit_end = (timer == '0);
  // Pop in IDLE, or at the end of STOP so queued bytes follow with no gap.
  assign pop = ~fifo_empty & ((state == TX_IDLE) | ((state == TX_STOP) & bit_end));

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .pop   (pop),
    .wdata (data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    rd_data = '0;
    if (hit_st) begin
      rd_data[ST_EMPTY_BIT]       = fifo_empty;
      rd_data[ST_FULL_BIT]        = fifo_full;
      rd_data[ST_BUSY_BIT]        = (state != TX_IDLE);
      rd_data[ST_OVF_BIT]         = overflow;
      rd_data[ST_COUNT_LSB +: 4]  = 4'(fifo_count);
    end else if (hit_div) begin
      rd_data[15:0] = div;
    end
  end

  assign data = rd_en ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wr_div) div <= data[15:0];
      // A new overflow event wins over the clear-on-read.
      if (wr_tx & fifo_full & ~pop) overflow <= 1'b1;
      else if (rd_st)               overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      txd     <= 1'b1;
      timer   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (pop) begin
            state <= TX_START;
            txd   <= 1'b0;
            timer <= div;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state   <= TX_DATA;
            txd     <= shift[0];
            timer   <= div;
            bit_cnt <= '0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            timer <= div;
            if (bit_cnt == 3'd7) begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end else begin
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        TX_STOP: begin
          if (bit_end) begin
            timer <= div;
            if (pop) begin
              state <= TX_START;
              txd   <= 1'b0;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop)                               shift <= fifo_rdata;
    else if ((state == TX_DATA) & bit_end) shift <= shift >> 1;
  end

endmodule
